// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared definitions for the SRAM arbiter slice.
//   - FSM state encoding for the fixed 4-cycle access sequence
//   - idle/active levels of the SRAM control pins
//   - default address/data widths of the 2048x32 SRAM
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  // Chip select is active-low; idle level deselects the SRAM.
  localparam logic CS_IDLE    = 1'b1;
  localparam logic CS_ACTIVE  = 1'b0;
  // Read/write strobe: high = read, low = write strobe.
  localparam logic RW_READ    = 1'b1;
  localparam logic RW_WRITE   = 1'b0;
  // Output enable as seen from the controller: 1 = controller drives the bus.
  localparam logic OE_DRIVE   = 1'b1;
  localparam logic OE_RELEASE = 1'b0;

endpackage

// File: rtl/sram_rr_pick.sv
// sram_rr_pick: combinational two-way round-robin picker.
// Ports:
//   req0, req1 : request levels of client 0 / client 1
//   last_gnt   : client that won the previous contended grant
//   valid      : at least one request present
//   winner     : selected client (0 or 1), meaningful only when valid
module sram_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

  // Lone requester wins outright; on contention the client that did not win last time goes.
  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_gnt;
    end else if (req1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-client, single-word SRAM access controller.
// Each accepted request runs a fixed IDLE -> SETUP -> STROBE -> RECOVER sequence.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   reqN, weN, addrN, wdataN      : client N request level, op (1=write), address, write data
//   gntN                          : one-cycle pulse, client N request accepted and latched
//   doneN                         : one-cycle pulse, client N access complete
//   rdata                         : last read result (shared)
//   busy                          : high whenever the controller is not idle
//   sram_data                     : bidirectional SRAM data bus
//   sram_addr, sram_oe, sram_cs,
//   sram_rw                       : SRAM address and control pins (all registered)
module sram_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_oe,
  output logic              sram_cs,
  output logic              sram_rw
);

  state_e              state_r, state_nxt_s;
  logic                we_r, we_nxt_s;
  logic                owner_r, owner_nxt_s;
  logic                last_gnt_r, last_gnt_nxt_s;
  logic [DATA_W-1:0]   wdata_r, wdata_nxt_s;
  logic [DATA_W-1:0]   rdata_nxt_s;
  logic [ADDR_W-1:0]   addr_nxt_s;
  logic                cs_nxt_s, rw_nxt_s, oe_nxt_s;
  logic                gnt0_nxt_s, gnt1_nxt_s, done0_nxt_s, done1_nxt_s, busy_nxt_s;
  logic                pick_valid_s, pick_winner_s;

  sram_rr_pick u_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt_r),
    .valid    (pick_valid_s),
    .winner   (pick_winner_s)
  );

  // The controller only drives the bus while sram_oe is set, i.e. during a write's SETUP/STROBE.
  assign sram_data = (sram_oe == OE_DRIVE) ? wdata_r : {DATA_W{1'bz}};

  // Next-state and next-output decode of the access sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    we_nxt_s       = we_r;
    owner_nxt_s    = owner_r;
    last_gnt_nxt_s = last_gnt_r;
    wdata_nxt_s    = wdata_r;
    rdata_nxt_s    = rdata;
    addr_nxt_s     = sram_addr;
    cs_nxt_s       = sram_cs;
    rw_nxt_s       = sram_rw;
    oe_nxt_s       = sram_oe;
    gnt0_nxt_s     = 1'b0;
    gnt1_nxt_s     = 1'b0;
    done0_nxt_s    = 1'b0;
    done1_nxt_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s = ST_SETUP;
          owner_nxt_s = pick_winner_s;
          we_nxt_s    = pick_winner_s ? we1 : we0;
          wdata_nxt_s = pick_winner_s ? wdata1 : wdata0;
          addr_nxt_s  = pick_winner_s ? addr1 : addr0;
          cs_nxt_s    = CS_ACTIVE;
          rw_nxt_s    = RW_READ;
          // A write takes the bus from SETUP onwards so data is stable before the strobe.
          oe_nxt_s    = pick_winner_s ? we1 : we0;
          gnt0_nxt_s  = ~pick_winner_s;
          gnt1_nxt_s  = pick_winner_s;
          // Fairness pointer only moves when both clients competed.
          if (req0 && req1) begin
            last_gnt_nxt_s = pick_winner_s;
          end else begin
            last_gnt_nxt_s = last_gnt_r;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_nxt_s = ST_STROBE;
        if (we_r) begin
          rw_nxt_s = RW_WRITE;
        end else begin
          rw_nxt_s = sram_rw;
        end
      end
      ST_STROBE: begin
        state_nxt_s = ST_RECOVER;
        rw_nxt_s    = RW_READ;
        cs_nxt_s    = CS_IDLE;
        oe_nxt_s    = OE_RELEASE;
        done0_nxt_s = ~owner_r;
        done1_nxt_s = owner_r;
        if (!we_r) begin
          rdata_nxt_s = sram_data;
        end else begin
          rdata_nxt_s = rdata;
        end
      end
      ST_RECOVER: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State register, latched request and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      we_r       <= 1'b0;
      owner_r    <= 1'b0;
      last_gnt_r <= 1'b1;
      wdata_r    <= {DATA_W{1'b0}};
      rdata      <= {DATA_W{1'b0}};
      sram_addr  <= {ADDR_W{1'b0}};
      sram_cs    <= CS_IDLE;
      sram_rw    <= RW_READ;
      sram_oe    <= OE_RELEASE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      we_r       <= we_nxt_s;
      owner_r    <= owner_nxt_s;
      last_gnt_r <= last_gnt_nxt_s;
      wdata_r    <= wdata_nxt_s;
      rdata      <= rdata_nxt_s;
      sram_addr  <= addr_nxt_s;
      sram_cs    <= cs_nxt_s;
      sram_rw    <= rw_nxt_s;
      sram_oe    <= oe_nxt_s;
      gnt0       <= gnt0_nxt_s;
      gnt1       <= gnt1_nxt_s;
      done0      <= done0_nxt_s;
      done1      <= done1_nxt_s;
      busy       <= busy_nxt_s;
    end
  end

endmodule
